line_main_memory: RTL
=====================

// Module: line_main_memory
// PURPOSE
//   Parametrised backing memory for the direct-mapped cache. Serves whole-line reads (refill) and whole-line
//   writes (write-back) over a valid/ready request/response handshake. Each access has a fixed, programmable
//   latency, so cache miss handling sees realistic stall timing. Sits below the cache controller; one request
//   in flight at a time.
// PARAMETERS
//   WORD_W          32    bits per word
//   WORDS_PER_LINE  4     words per cache line; power of two, >=2
//   ADDR_W          15    word-address width
//   DEPTH_WORDS     32768 implemented words; multiple of WORDS_PER_LINE, <= 2**ADDR_W
//   LATENCY         4     cycles from request accept edge to resp_valid rising; >=1
// PORTS
//   clk         in   1                      clock, rising edge
//   rst         in   1                      reset, asynchronous, active-high
//   req_valid   in   1                      request present
//   req_ready   out  1                      block can accept a request
//   req_write   in   1                      1 = line write, 0 = line read
//   req_addr    in   ADDR_W                 word address; low log2(WORDS_PER_LINE) bits ignored
//   req_wdata   in   WORD_W*WORDS_PER_LINE  write line; word i at [i*WORD_W +: WORD_W]
//   resp_valid  out  1                      response present
//   resp_ready  in   1                      consumer takes response
//   resp_rdata  out  WORD_W*WORDS_PER_LINE  read line (reads) / written line echo (writes)
//   resp_err    out  1                      access out of range; qualified by resp_valid
//   busy        out  1                      high in any state other than IDLE
// BEHAVIOUR
//   - Reset: state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, busy=0, counter=0.
//     Reset does not clear memory contents.
//   - FSM IDLE -> WAIT -> RESP -> IDLE.
//     IDLE: req_ready=1. On req_valid: latch write flag, line base (addr with low bits zeroed) and wdata;
//       counter=LATENCY-1. Go to WAIT, or to RESP directly if LATENCY==1.
//     WAIT: counter decrements each cycle. At counter==0 the access is performed:
//       - read: resp_rdata = line words base..base+WPL-1, word i at [i*WORD_W +: WORD_W];
//       - write: store the latched line, resp_rdata = latched wdata.
//       Set resp_valid=1 and go to RESP.
//     RESP: outputs held stable until resp_valid && resp_ready, then resp_valid=0 and return to IDLE.
//       req_ready=0, so the next accept is no earlier than the cycle after the handshake.
//   - Latency: accept on edge N gives resp_valid high after edge N+LATENCY.
//   - Out of range (base >= DEPTH_WORDS): no storage access, no write; resp_rdata=0, resp_err=1, same timing.
//   - Word addresses base+i never cross a line; there is no wrap-around inside a line.
//   - req_valid while busy is ignored. The requester must hold it; nothing is queued.
//   - rst asserted mid-WAIT/RESP aborts the access: the pending write is discarded and no response is issued.
//   - Read-after-write to the same line (back to back) returns the newly written data.
// STRUCTURE
//   - Package line_mem_pkg:
//     - LINE_W = WORD_W*WORDS_PER_LINE;
//     - OFS_W = $clog2(WORDS_PER_LINE);
//     - state enum {ST_IDLE, ST_WAIT, ST_RESP};
//     - function line_base(addr).
//   - Sub-module line_mem_array: synchronous line-wide storage with DEPTH_WORDS/WORDS_PER_LINE entries,
//     one read/write port, index = base>>OFS_W, contents preloadable via $readmemh.
//   - Top level holds the FSM, latency counter, request latches and response registers.
// TESTING
//   - Reset/idle: rst pulse -> req_ready=1, resp_valid=0, busy=0; no response appears over 20 idle cycles.
//   - Read latency: preload line 0x0010 with words A0..A3; read addr 0x0042 at edge N -> resp_valid after
//     edge N+4, resp_rdata={A3,A2,A1,A0}, resp_err=0.
//   - Write then read: write addr 0x0100 with 128'h1111_2222_3333_4444_5555_6666_7777_8888; read 0x0103
//     -> same 128-bit value; neighbouring line 0x0104 is unchanged.
//   - Backpressure: hold resp_ready=0 for 7 cycles -> resp_valid/resp_rdata stable, req_ready=0, a second
//     req_valid is ignored; release -> exactly one handshake, then IDLE.
//   - Range/param: DEPTH_WORDS=1024, read 0x0400 -> resp_err=1, rdata=0; a write there leaves memory
//     unchanged; LATENCY=1 build -> resp_valid after edge N+1.
//   - Reset mid-op: write to 0x0200 with rst at 2 cycles into WAIT -> no resp_valid; a later read of
//     0x0200 returns the old contents.

Source files
------------

// File: rtl/line_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : line_mem_pkg
// Purpose  : Shared types, default geometry and address helpers for the
//            line-oriented backing memory.
// Contents : DEF_* default geometry, LINE_W / OFS_W for that geometry,
//            state_t FSM encoding, line_base() helper.
// Revision : 1.0  initial release
// ============================================================================
package line_mem_pkg;

  localparam int DEF_WORD_W         = 32;
  localparam int DEF_WORDS_PER_LINE = 4;
  localparam int DEF_ADDR_W         = 15;
  localparam int DEF_DEPTH_WORDS    = 32768;
  localparam int DEF_LATENCY        = 4;

  // Geometry of the default build.
  localparam int LINE_W = DEF_WORD_W * DEF_WORDS_PER_LINE;
  localparam int OFS_W  = $clog2(DEF_WORDS_PER_LINE);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Clear the word-offset bits so any word address maps to its line's
  // first word.
  function automatic logic [31:0] line_base(input logic [31:0] addr,
                                            input int unsigned ofs_w);
    return addr & ~((32'd1 << ofs_w) - 32'd1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/line_mem_array.sv
`default_nettype none
// ============================================================================
// Module   : line_mem_array
// Purpose  : Synchronous single-port, line-wide storage. A write stores
//            wdata at idx; a read registers mem[idx] into rdata on the same
//            edge. The storage array is named mem so it can be preloaded
//            from outside by hierarchical reference to <inst>.mem.
// Ports    : clk, rst (async, clears only the read register),
//            en (access strobe), we (1 = write), idx (line index),
//            wdata (line to store), rdata (registered read line).
// Revision : 1.0  initial release
// ============================================================================
module line_mem_array
  import line_mem_pkg::*;
#(
  parameter int DATA_W  = LINE_W,
  parameter int ENTRIES = DEF_DEPTH_WORDS / DEF_WORDS_PER_LINE,
  parameter int IDX_W   = (ENTRIES > 1) ? $clog2(ENTRIES) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [ENTRIES];

  // Contents survive reset on purpose: only the read register is cleared.
  always_ff @(posedge clk) begin
    if (en && we) begin
      mem[idx] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
    end else if (en && !we) begin
      rdata <= mem[idx];
    end
  end

endmodule
`default_nettype wire

// File: rtl/line_main_memory.sv
`default_nettype none
// ============================================================================
// Module   : line_main_memory
// Purpose  : Backing memory for the direct-mapped cache. Accepts one
//            whole-line read or write at a time over a valid/ready pair and
//            answers after a fixed LATENCY, holding the response until it
//            is consumed.
// Ports    : clk, rst (async, active-high)
//            req_valid/req_ready/req_write/req_addr/req_wdata  - request
//            resp_valid/resp_ready/resp_rdata/resp_err         - response
//            busy - high whenever an access is pending or being presented
// Revision : 1.0  initial release
// ============================================================================
module line_main_memory
  import line_mem_pkg::*;
#(
  parameter int WORD_W         = DEF_WORD_W,
  parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE,
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int DEPTH_WORDS    = DEF_DEPTH_WORDS,
  parameter int LATENCY        = DEF_LATENCY
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic                             req_write,
  input  logic [ADDR_W-1:0]                req_addr,
  input  logic [WORD_W*WORDS_PER_LINE-1:0] req_wdata,
  output logic                             resp_valid,
  input  logic                             resp_ready,
  output logic [WORD_W*WORDS_PER_LINE-1:0] resp_rdata,
  output logic                             resp_err,
  output logic                             busy
);

  localparam int LINE_BITS = WORD_W * WORDS_PER_LINE;
  localparam int OFS_BITS  = $clog2(WORDS_PER_LINE);
  localparam int ENTRIES   = DEPTH_WORDS / WORDS_PER_LINE;
  localparam int IDX_W     = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam int CNT_W     = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  // One extra bit so DEPTH_WORDS == 2**ADDR_W is representable.
  localparam logic [ADDR_W:0]  DEPTH_L   = DEPTH_WORDS[ADDR_W:0];
  localparam logic [CNT_W-1:0] CNT_START = CNT_W'(LATENCY - 1);

  state_t                state;
  logic [CNT_W-1:0]      cnt;
  logic                  wr_q;
  logic                  err_q;
  logic [ADDR_W-1:0]     base_q;
  logic [LINE_BITS-1:0]  wdata_q;

  logic [ADDR_W-1:0]     req_base;
  logic                  req_oor;
  logic                  mem_en;
  logic [IDX_W-1:0]      mem_idx;
  logic [LINE_BITS-1:0]  mem_rdata;

  assign req_base = ADDR_W'(line_base(32'(req_addr), OFS_BITS));
  assign req_oor  = ({1'b0, req_base} >= DEPTH_L);

  // The storage is touched exactly once per access, on the edge that raises
  // resp_valid. Out-of-range accesses never enable it, so a truncated index
  // cannot alias onto a real line.
  assign mem_en  = (state == ST_WAIT) && (cnt == '0) && !err_q;
  assign mem_idx = IDX_W'(base_q >> OFS_BITS);

  line_mem_array #(
    .DATA_W  (LINE_BITS),
    .ENTRIES (ENTRIES),
    .IDX_W   (IDX_W)
  ) u_array (
    .clk   (clk),
    .rst   (rst),
    .en    (mem_en),
    .we    (wr_q),
    .idx   (mem_idx),
    .wdata (wdata_q),
    .rdata (mem_rdata)
  );

  // Response data source: zero for out-of-range, echo of the latched line
  // for writes, the array's read register for reads. All three sources are
  // registers that hold still while in RESP, so the output is stable.
  assign resp_rdata = err_q ? '0 : (wr_q ? wdata_q : mem_rdata);
  assign resp_err   = err_q;

  // With LATENCY == 1 the counter starts at 0, so the single latency cycle
  // is spent in WAIT and the access lands on the edge after the accept,
  // keeping the accept-to-valid distance equal to LATENCY in every build.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      wr_q       <= 1'b0;
      err_q      <= 1'b0;
      base_q     <= '0;
      wdata_q    <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            wr_q      <= req_write;
            err_q     <= req_oor;
            base_q    <= req_base;
            wdata_q   <= req_wdata;
            cnt       <= CNT_START;
            state     <= ST_WAIT;
            req_ready <= 1'b0;
            busy      <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (cnt == '0) begin
            resp_valid <= 1'b1;
            state      <= ST_RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            busy       <= 1'b0;
            state      <= ST_IDLE;
          end
        end
        default: begin
          resp_valid <= 1'b0;
          req_ready  <= 1'b1;
          busy       <= 1'b0;
          state      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
